// File: rtl/pc_pkg.sv
// pc_gen shared types and constants: state encoding, word step, default vectors.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pc_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  localparam logic [XLEN-1:0] PC_DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_DEF_TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic {
    PC_BOOT = 1'b0,
    PC_RUN  = 1'b1
  } pc_state_e;

  // Clear the byte-offset bits so the address lands on an instruction word.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(PC_STEP - 1);
  endfunction

endpackage

// File: rtl/pc_boot_timer.sv
// Boot delay timer: counts clocks while enabled, o_done once the count equals BOOT_DELAY.
// Latency: o_done is a registered-count compare, high BOOT_DELAY edges after reset release.
// Backpressure: none; the counter freezes once done so it never wraps.
module pc_boot_timer
  import pc_pkg::*;
#(
  parameter logic [7:0] BOOT_DELAY = 8'd4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_done
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign o_done = (cnt_q == BOOT_DELAY);

  // Advance while the owner is still booting; stop at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (i_en && !o_done) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: boot delay, then sequential PCs over valid/ready with redirects.
// Latency: redirect or handshake updates o_pc on the next edge; o_pc_valid is combinational.
// Backpressure: o_pc/o_pc_valid hold while valid & ~ready (a redirect may still replace o_pc).
// Build option: PC_GEN_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VECTOR and pulses o_misaligned.
module pc_gen
  import pc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = PC_DEF_RESET_VECTOR,
  parameter int unsigned     BOOT_DELAY   = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = PC_DEF_TRAP_VECTOR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_pc_ready,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pc_valid,
  output logic [XLEN-1:0] o_fetch_cnt,
  output logic            o_misaligned
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
  logic            pend_vld_q, pend_vld_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            mis_q, mis_d;

  logic            boot_done;
  logic            fire;
  logic [XLEN-1:0] redir_src;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_mis;

  pc_boot_timer #(
    .BOOT_DELAY (8'(BOOT_DELAY))
  ) u_boot_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (state_q == PC_BOOT),
    .o_done (boot_done)
  );

  assign o_pc_valid   = (state_q == PC_RUN) && !i_stall;
  assign fire         = o_pc_valid && i_pc_ready;
  assign o_pc         = pc_q;
  assign o_fetch_cnt  = fetch_cnt_q;
  assign o_misaligned = mis_q;

  // A redirect arriving on the BOOT->RUN edge is the newest target, so it beats the pending one.
  assign redir_src = (state_q == PC_BOOT && !i_redirect_valid) ? pend_pc_q : i_redirect_pc;

`ifdef PC_GEN_MISALIGN_TRAP_EN
  assign redir_mis = |redir_src[1:0];
  assign redir_tgt = redir_mis ? TRAP_VECTOR : redir_src;
`else
  logic unused_trap;
  assign unused_trap = ^TRAP_VECTOR;
  assign redir_mis   = 1'b0;
  assign redir_tgt   = pc_align(redir_src);
`endif

  // Next-state, PC priority (redirect > handshake > hold) and saturating fetch count.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_pc_d   = pend_pc_q;
    mis_d       = 1'b0;
    unique case (state_q)
      PC_BOOT: begin
        if (i_redirect_valid) begin
          pend_vld_d = 1'b1;
          pend_pc_d  = i_redirect_pc;
        end
        if (boot_done) begin
          state_d    = PC_RUN;
          pend_vld_d = 1'b0;
          if (pend_vld_q || i_redirect_valid) begin
            pc_d  = redir_tgt;
            mis_d = redir_mis;
          end
        end
      end
      PC_RUN: begin
        if (fire && (fetch_cnt_q != '1)) begin
          fetch_cnt_d = fetch_cnt_q + XLEN'(1);
        end
        if (i_redirect_valid) begin
          pc_d  = redir_tgt;
          mis_d = redir_mis;
        end else if (fire) begin
          pc_d = pc_q + XLEN'(PC_STEP);
        end
      end
      default: state_d = PC_BOOT;
    endcase
  end

  // State registers; reset drops any in-flight handshake and pending redirect at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= PC_BOOT;
      pc_q        <= RESET_VECTOR;
      fetch_cnt_q <= '0;
      pend_vld_q  <= 1'b0;
      pend_pc_q   <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_pc_q   <= pend_pc_d;
      mis_q       <= mis_d;
    end
  end

endmodule
